// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake, status strobes and PS/2 line signals of the host transmitter
interface ps2_host_tx_if;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic       o_busy;
  logic       o_done;
  logic       o_err;
  logic       i_ps2_clk;
  logic       i_ps2_dat;
  logic       o_ps2_clk_oe;
  logic       o_ps2_dat_oe;
  modport master (
    output i_data, i_valid, i_ps2_clk, i_ps2_dat,
    input  o_ready, o_busy, o_done, o_err, o_ps2_clk_oe, o_ps2_dat_oe
  );
  modport slave (
    input  i_data, i_valid, i_ps2_clk, i_ps2_dat,
    output o_ready, o_busy, o_done, o_err, o_ps2_clk_oe, o_ps2_dat_oe
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter with inhibit, odd parity, ACK check and timeout
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input logic          i_clk,
  input logic          i_rst,
  ps2_host_tx_if.slave bus
);
  localparam int CW_T = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW_I = $clog2(INHIBIT_CYCLES + 1);
  localparam int CW_M = CW_T > CW_I ? CW_T : CW_I;
  localparam int CW = CW_M > 20 ? CW_M : 20;
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LIM = CW'(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {IDLE, INHIBIT, START, TX, ACK, WAIT_IDLE} state_t;
  state_t        state, next;
  logic          clk_s1, clk_s2, clk_q, dat_s1, dat_s2;
  logic [CW-1:0] cnt;
  logic [3:0]    idx;
  logic [7:0]    data;
  logic          par, dat_q, ack_q;
  logic [9:0]    frame;
  logic          fall, accept, active, tmo;
  assign frame  = {1'b1, par, data};
  assign fall   = clk_q & ~clk_s2;
  assign accept = bus.i_valid & (state == IDLE);
  assign active = (state == TX) | (state == ACK) | (state == WAIT_IDLE);
  assign tmo    = active & (cnt >= TMO_LIM);
  // state register
  always_ff @(posedge i_clk)
    if (i_rst) state <= IDLE;
    else state <= next;
  // next-state decode; timeout overrides any coincident fall or line-idle condition
  always_comb begin
    next = state;
    unique case (state)
      IDLE:      next = bus.i_valid ? INHIBIT : IDLE;
      INHIBIT:   next = (cnt == INH_LAST) ? START : INHIBIT;
      START:     next = TX;
      TX:        next = tmo ? IDLE : (fall && idx == 4'd9) ? ACK : TX;
      ACK:       next = tmo ? IDLE : fall ? (dat_s2 ? IDLE : WAIT_IDLE) : ACK;
      WAIT_IDLE: next = (tmo || (clk_s2 && dat_s2)) ? IDLE : WAIT_IDLE;
      default:   next = IDLE;
    endcase
  end
  // synchronizers, byte/parity latch, shared inhibit/timeout counter, bit index and data line hold
  always_ff @(posedge i_clk)
    if (i_rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_q  <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
      cnt    <= '0;
      idx    <= '0;
      data   <= '0;
      par    <= 1'b0;
      dat_q  <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      clk_s1 <= bus.i_ps2_clk;
      clk_s2 <= clk_s1;
      clk_q  <= clk_s2;
      dat_s1 <= bus.i_ps2_dat;
      dat_s2 <= dat_s1;
      if (accept) begin
        data <= bus.i_data;
        par  <= ~^bus.i_data;
      end
      cnt   <= (accept || state == START) ? '0 :
               (state == INHIBIT || (active && ~&cnt)) ? cnt + 1'b1 : cnt;
      idx   <= (state == START) ? 4'd0 : (state == TX && fall) ? idx + 4'd1 : idx;
      dat_q <= (state == START) ? 1'b1 : (state == TX && fall) ? ~frame[idx] : dat_q;
      ack_q <= (state == ACK && fall && !dat_s2) ? 1'b1 : (state == IDLE) ? 1'b0 : ack_q;
    end
  // outputs: open-drain enables from state, Mealy done/err strobes suppressed while in reset
  always_comb begin
    bus.o_ready      = state == IDLE;
    bus.o_busy       = state != IDLE;
    bus.o_ps2_clk_oe = (state == INHIBIT) | (state == START);
    bus.o_ps2_dat_oe = (state == START) | (((state == TX) | (state == ACK)) & dat_q & ~tmo);
    bus.o_done       = ~i_rst & (state == WAIT_IDLE) & ack_q & clk_s2 & dat_s2 & ~tmo;
    bus.o_err        = ~i_rst & (tmo | ((state == ACK) & fall & dat_s2));
  end
endmodule
